// File: rtl/m_compresor_pkg.sv
// Shared definitions for the instruction-word dictionary compressor and its
// decompressor counterpart: FSM state encoding, default geometry and the
// token layout that travels between them.
package compresor_pkg;

    localparam int DEF_INSTR_W    = 32;
    localparam int DEF_DICT_DEPTH = 16;
    localparam int DEF_IDX_W      = 4;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One compressed token: a literal word, or a zero-extended dictionary index.
    typedef struct packed {
        logic                   is_lit;
        logic [DEF_INSTR_W-1:0] data;
        logic                   last;
    } token_t;

    // Zero-extend a dictionary index into an instruction-wide data field.
    function automatic logic [DEF_INSTR_W-1:0] idx_to_data(input logic [DEF_IDX_W-1:0] idx);
        idx_to_data = {{(DEF_INSTR_W-DEF_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/m_compresor_dict.sv
// Dictionary storage for the compressor: entry array, per-entry valid bits,
// FIFO write pointer and a fill count. Valid entries always occupy a
// contiguous run starting at 0 until the array is full, so the fill count
// is the number of entries the search has to visit.
module comp_dict import compresor_pkg::*; #(
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int IDX_W      = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [INSTR_W-1:0] rd_entry,
    output logic               rd_valid,
    output logic [IDX_W:0]     fill,
    input  logic               wr_en,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               clr
);

    localparam logic [IDX_W:0] FILL_FULL = (IDX_W+1)'(DICT_DEPTH);

    logic [INSTR_W-1:0]    entry_r [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] valid_r;
    logic [IDX_W-1:0]      wr_ptr_r;
    logic [IDX_W:0]        fill_r;

    // Bookkeeping: valid bits, FIFO pointer and fill count; reset and clear empty the dictionary.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            fill_r   <= '0;
        end else if (wr_en) begin
            valid_r[wr_ptr_r] <= 1'b1;
            // DICT_DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_r <= wr_ptr_r + IDX_W'(1);
            if (fill_r != FILL_FULL) begin
                fill_r <= fill_r + (IDX_W+1)'(1);
            end
        end
    end

    // Entry storage: the missed word lands in the slot the FIFO pointer selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DICT_DEPTH; k++) begin
                entry_r[k] <= '0;
            end
        end else if (wr_en && !clr) begin
            entry_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_entry = entry_r[rd_idx];
    assign rd_valid = valid_r[rd_idx];
    assign fill     = fill_r;

endmodule

// File: rtl/m_compresor.sv
// Streaming dictionary compressor for instruction words. Each accepted word
// is searched linearly against the dictionary (one entry per cycle) and
// turned into an index token on a hit or a literal token on a miss. Misses
// are appended FIFO-style; the dictionary empties at the end of each stream
// so the decompressor can rebuild it with the same rule.
module m_compresor import compresor_pkg::*; #(
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_is_lit,
    output logic [INSTR_W-1:0] out_data,
    output logic               out_last,
    output logic               done,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   lit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_r;
    logic [INSTR_W-1:0] word_r;
    logic               last_r;
    logic [IDX_W-1:0]   idx_r;
    token_t             tok_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               done_r;
    logic [CNT_W-1:0]   hit_cnt_r;
    logic [CNT_W-1:0]   lit_cnt_r;

    logic [INSTR_W-1:0] rd_entry_s;
    logic               rd_valid_s;
    logic [IDX_W:0]     fill_s;
    logic [IDX_W:0]     last_idx_s;
    logic               match_s;
    logic               miss_s;
    logic               clr_s;

    comp_dict #(
        .INSTR_W    (INSTR_W),
        .DICT_DEPTH (DICT_DEPTH),
        .IDX_W      (IDX_W)
    ) u_dict (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_r),
        .rd_entry (rd_entry_s),
        .rd_valid (rd_valid_s),
        .fill     (fill_s),
        .wr_en    (miss_s),
        .wr_data  (word_r),
        .clr      (clr_s)
    );

    // Search verdict for the entry under the index: hit, miss or keep scanning.
    always_comb begin
        match_s    = 1'b0;
        miss_s     = 1'b0;
        last_idx_s = fill_s - (IDX_W+1)'(1);
        if (state_r == SEARCH) begin
            if (fill_s == '0) begin
                // Empty dictionary: nothing to compare, miss right away.
                miss_s = 1'b1;
            end else if (rd_valid_s && (rd_entry_s == word_r)) begin
                match_s = 1'b1;
            end else if ({1'b0, idx_r} == last_idx_s) begin
                // Last valid entry compared without a match.
                miss_s = 1'b1;
            end else begin
                miss_s = 1'b0;
            end
        end else begin
            match_s = 1'b0;
            miss_s  = 1'b0;
        end
    end

    assign clr_s = (state_r == DONE);

    // Control FSM with registered handshake and token outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            word_r      <= '0;
            last_r      <= 1'b0;
            idx_r       <= '0;
            tok_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        word_r     <= in_instr;
                        last_r     <= in_last;
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= SEARCH;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (match_s) begin
                        tok_r.is_lit <= 1'b0;
                        tok_r.data   <= idx_to_data(idx_r);
                        tok_r.last   <= last_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= EMIT;
                    end else if (miss_s) begin
                        tok_r.is_lit <= 1'b1;
                        tok_r.data   <= word_r;
                        tok_r.last   <= last_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= EMIT;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                EMIT: begin
                    // Token is held untouched until the consumer takes it.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        tok_r       <= '0;
                        if (tok_r.last) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            in_ready_r <= 1'b1;
                            state_r    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Saturating statistics, stepped on each accepted token; kept across streams.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r <= '0;
            lit_cnt_r <= '0;
        end else if ((state_r == EMIT) && out_ready) begin
            if (tok_r.is_lit) begin
                if (lit_cnt_r != CNT_MAX) begin
                    lit_cnt_r <= lit_cnt_r + CNT_W'(1);
                end
            end else begin
                if (hit_cnt_r != CNT_MAX) begin
                    hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_is_lit = tok_r.is_lit;
    assign out_data   = tok_r.data;
    assign out_last   = tok_r.last;
    assign done       = done_r;
    assign hit_count  = hit_cnt_r;
    assign lit_count  = lit_cnt_r;

endmodule

// File: tb/tb_m_compresor.sv
// Directed bench for m_compresor: token values, search latency, FIFO
// wrap-around, back-pressure, stream boundary and mid-search reset.
module tb_m_compresor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_lit;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic [15:0] hit_count;
    logic [15:0] lit_count;

    int checks   = 0;
    int failures = 0;
    int exp_hit  = 0;
    int exp_lit  = 0;

    m_compresor dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_lit (out_is_lit),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done),
        .hit_count  (hit_count),
        .lit_count  (lit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word and return #1 after the edge that accepted it.
    task automatic send(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_instr = w;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid shows (1 means cycle T+2).
    task automatic wait_tok(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transfer with out_ready high: check the token, then let it be taken.
    task automatic xfer(input logic [31:0] w, input logic l, input logic e_lit,
                        input logic [31:0] e_data, input int e_lat, input string tag);
        int lat;
        send(w, l);
        wait_tok(lat);
        chk({tag, "_lat"},  lat,        e_lat);
        chk({tag, "_lit"},  out_is_lit, {31'd0, e_lit});
        chk({tag, "_data"}, out_data,   e_data);
        chk({tag, "_last"}, out_last,   {31'd0, l});
        if (e_lit) exp_lit++; else exp_hit++;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,   32'd0);
        chk("rst_out_valid", out_valid,  32'd0);
        chk("rst_is_lit",    out_is_lit, 32'd0);
        chk("rst_data",      out_data,   32'd0);
        chk("rst_last",      out_last,   32'd0);
        chk("rst_done",      done,       32'd0);
        chk("rst_hits",      hit_count,  32'd0);
        chk("rst_lits",      lit_count,  32'd0);
        rst = 1'b0;

        // 1: basic stream
        xfer(32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 1, "t1_a");
        xfer(32'h0000_0013, 1'b0, 1'b0, 32'd0,         1, "t1_b");
        xfer(32'h00A0_0093, 1'b1, 1'b1, 32'h00A0_0093, 1, "t1_c");
        chk("t1_done_hi", done, 32'd1);
        @(posedge clk); #1;
        chk("t1_done_lo", done, 32'd0);
        chk("t1_hits", hit_count, exp_hit);
        chk("t1_lits", lit_count, exp_lit);

        // 2: latency (misses at n=1,2,3 take 1,2,3 edges; hit at 3 takes 4)
        xfer(32'h200, 1'b0, 1'b1, 32'h200, 1, "t2_first");
        xfer(32'h200, 1'b0, 1'b0, 32'd0,   1, "t2_hit0");
        xfer(32'h201, 1'b0, 1'b1, 32'h201, 1, "t2_m1");
        xfer(32'h202, 1'b0, 1'b1, 32'h202, 2, "t2_m2");
        xfer(32'h203, 1'b0, 1'b1, 32'h203, 3, "t2_m3");
        xfer(32'h203, 1'b1, 1'b0, 32'd3,   4, "t2_hit3");
        chk("t2_hits", hit_count, exp_hit);
        chk("t2_lits", lit_count, exp_lit);

        // 3: wrap-around on a fresh dictionary
        for (int i = 0; i < 16; i++) begin
            xfer(32'h100 + i, 1'b0, 1'b1, 32'h100 + i, (i == 0) ? 1 : i, "t3_fill");
        end
        // 0x110 lands in entry 0, evicting 0x100
        xfer(32'h110, 1'b0, 1'b1, 32'h110, 16, "t3_evict");
        // 0x100 misses and lands in entry 1, evicting 0x101
        xfer(32'h100, 1'b0, 1'b1, 32'h100, 16, "t3_re100");
        // so 0x101 misses too and lands in entry 2
        xfer(32'h101, 1'b0, 1'b1, 32'h101, 16, "t3_re101");
        xfer(32'h100, 1'b0, 1'b0, 32'd1,   2,  "t3_hit1");
        xfer(32'h103, 1'b0, 1'b0, 32'd3,   4,  "t3_hit3");
        xfer(32'h110, 1'b1, 1'b0, 32'd0,   1,  "t3_hit0");
        chk("t3_hits", hit_count, exp_hit);
        chk("t3_lits", lit_count, exp_lit);

        // 4: back-pressure
        out_ready = 1'b0;
        send(32'h300, 1'b0);
        wait_tok(lat);
        chk("t4_lat", lat, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", out_valid, 32'd1);
            chk("t4_hold_data",  out_data,  32'h300);
            chk("t4_hold_ready", in_ready,  32'd0);
        end
        chk("t4_hold_lits", lit_count, exp_lit);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_lit++;
        chk("t4_taken_valid", out_valid, 32'd0);
        chk("t4_taken_lits",  lit_count, exp_lit);
        @(posedge clk); #1;
        chk("t4_once_valid", out_valid, 32'd0);
        chk("t4_once_lits",  lit_count, exp_lit);
        xfer(32'h300, 1'b1, 1'b0, 32'd0, 1, "t4_hit");

        // 5: stream boundary clears the dictionary, counters carry on
        xfer(32'h0000_0013, 1'b1, 1'b1, 32'h0000_0013, 1, "t5_a");
        xfer(32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 1, "t5_b");
        chk("t5_hits", hit_count, exp_hit);
        chk("t5_lits", lit_count, exp_lit);

        // 6: reset while searching (0x13 is in entry 0 before the reset)
        send(32'h400, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 32'd0);
        chk("t6_in_ready",  in_ready,  32'd0);
        chk("t6_done",      done,      32'd0);
        @(posedge clk); #1;
        chk("t6_idle_ready", in_ready, 32'd1);
        exp_hit = 0;
        exp_lit = 0;
        xfer(32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 1, "t6_a");
        chk("t6_hits", hit_count, 32'd0);
        chk("t6_lits", lit_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
